alu_issue_wb: RTL and testbench
===============================

Name: alu_issue_wb

Overview:
Issue/writeback stage wrapped around the combinational priority ALU. It accepts register-level commands over a valid/ready stream and holds a small register file. It drives the ALU's bus_a, bus_b and alu_sel from an execute register, then captures alu_out and the flags into a writeback register that updates the register file and presents a result stream downstream. It is a 2-entry pipeline with full-throughput backpressure and no data hazards.

Parameters:
WIDTH, 8, datapath width; matches the ALU.
W_ALU_SEL, 3, ALU select width.
NREGS, 4, register-file depth.
REG_AW, 2, register address width; must equal $clog2(NREGS).

Ports:
clk  in  1  clock; all state is on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  stage accepts a command this cycle.
cmd_op  in  W_ALU_SEL  001 add, 010 sub, 011 mul, 100 div2, 111 LDI (load immediate), others pass bus_a.
cmd_ra  in  REG_AW  source register.
cmd_rd  in  REG_AW  destination register.
cmd_imm  in  WIDTH  signed immediate; used as bus_b, or as the load value for LDI.
bus_a  out  WIDTH  signed ALU operand A.
bus_b  out  WIDTH  signed ALU operand B.
alu_sel  out  W_ALU_SEL  ALU select.
alu_out  in  WIDTH  signed ALU result.
flag_n  in  1  ALU negative flag.
flag_c  in  1  ALU zero flag (result == 0).
res_valid  out  1  result present.
res_ready  in  1  downstream accepts the result.
res_data  out  WIDTH  result value.
res_rd  out  REG_AW  destination register of the result.
res_flag_n  out  1  registered negative flag.
res_flag_z  out  1  registered zero flag.

Behaviour:
- Reset (async assert, sync release):
  - e_valid=0, res_valid=0, res_data=0, res_rd=0, res_flag_n=0, res_flag_z=0.
  - All register-file entries are 0.
  - E-stage op/ra/rd/imm fields are 0, so bus_a=0, bus_b=0, alu_sel=000 after reset.
- Execute stage E: registers op, ra, rd and imm on cmd_valid && cmd_ready.
- ALU drive (combinational from E):
  - op 111: bus_a=imm, bus_b=0, alu_sel=000.
  - Otherwise: bus_a=rf[ra], bus_b=imm, alu_sel=op.
- Writeback stage W:
  - w_ready = !res_valid || res_ready.
  - When e_valid && w_ready, at the edge:
    - res_data<=alu_out, res_rd<=rd, res_flag_n<=flag_n, res_flag_z<=flag_c, res_valid<=1.
    - rf[rd]<=alu_out in the same edge.
  - Else if res_ready, res_valid<=0.
- cmd_ready = !e_valid || w_ready (combinational).
  - e_valid<=1 when a command is accepted.
  - e_valid<=0 when E drains with no new command.
- Latency: a command accepted at edge k drives the ALU in cycle k+1 and appears on res_* from edge k+1. This gives one result per cycle with res_ready held high.
- No hazards: the rf write and the E load of the next command share an edge, so the next command reads the updated rf. Back-to-back dependent commands need no forwarding and no bubble.
- Stall: with res_valid=1, res_ready=0 and e_valid=1:
  - cmd_ready=0.
  - E and W hold.
  - bus_a, bus_b, alu_sel and all res_* stay stable.
- Arithmetic is owned by the ALU: results truncate to WIDTH, two's complement; div2 truncates toward zero. This stage performs no width extension.
- A read of rf[ra] while W writes the same register in that cycle returns the old value for the current E command. That value is correct because the current E command was issued after the previous write.
- Reset mid-operation drops E and W contents; the register file clears.

Decomposition:
- Shared package alu_pkg:
  - WIDTH and W_ALU_SEL constants.
  - alu_op_e enum: OP_PASS=000, OP_ADD=001, OP_SUB=010, OP_MUL=011, OP_DIV2=100, OP_LDI=111.
  - cmd_t struct: op, ra, rd, imm.
- No sub-module: the register file is an internal array and the ALU is instantiated beside this block at the next level up.

Test Plan:
1. Reset -> cmd_ready=1, res_valid=0, bus_a=0. Issue OP_PASS ra=2 imm=0 -> res_data=0, res_flag_z=1.
2. LDI r1,5; then ADD rd=2 ra=1 imm=-3 on consecutive cycles with res_ready=1 -> results 5, then 2 one cycle apart; rf[2]=2.
3. SUB rd=3 ra=1 imm=5 -> res_data=0, res_flag_z=1, res_flag_n=0. MUL rd=0 ra=1 imm=-30 -> res_data=8'h6A (truncated -150), flag_n=0.
4. LDI r1,-7; DIV2 rd=1 ra=1 -> res_data=8'hFD (-3), res_flag_n=1.
5. res_ready=0 for 5 cycles while cmd_valid=1 with 3 commands -> only 2 accepted, cmd_ready=0, res_* stable. Release res_ready -> all 3 results delivered in order, no loss or duplicates.
6. Assert rst_n=0 with E and W full -> res_valid=0 immediately, rf cleared. After release, ADD ra=1 imm=1 -> res_data=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue/writeback stage and its neighbours.
package alu_pkg;

  localparam int WIDTH     = 8;
  localparam int W_ALU_SEL = 3;
  localparam int NREGS     = 4;
  localparam int REG_AW    = $clog2(NREGS);

  typedef enum logic [W_ALU_SEL-1:0] {
    OP_PASS = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_MUL  = 3'b011,
    OP_DIV2 = 3'b100,
    OP_LDI  = 3'b111
  } alu_op_e;

  // op stays raw bits: codes 101/110 are legal and mean "pass bus_a".
  typedef struct packed {
    logic [W_ALU_SEL-1:0] op;
    logic [REG_AW-1:0]    ra;
    logic [REG_AW-1:0]    rd;
    logic [WIDTH-1:0]     imm;
  } cmd_t;

endpackage

// File: rtl/alu_issue_wb_if.sv
// Command stream, result stream and ALU operand/result bus of the issue/writeback stage.
interface alu_issue_wb_if;
  import alu_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [W_ALU_SEL-1:0] cmd_op;
  logic [REG_AW-1:0]    cmd_ra;
  logic [REG_AW-1:0]    cmd_rd;
  logic [WIDTH-1:0]     cmd_imm;

  logic [WIDTH-1:0]     bus_a;
  logic [WIDTH-1:0]     bus_b;
  logic [W_ALU_SEL-1:0] alu_sel;
  logic [WIDTH-1:0]     alu_out;
  logic                 flag_n;
  logic                 flag_c;

  logic                 res_valid;
  logic                 res_ready;
  logic [WIDTH-1:0]     res_data;
  logic [REG_AW-1:0]    res_rd;
  logic                 res_flag_n;
  logic                 res_flag_z;

  // master: command source, result sink and the ALU itself.
  modport master (
    output cmd_valid, cmd_op, cmd_ra, cmd_rd, cmd_imm,
    output alu_out, flag_n, flag_c,
    output res_ready,
    input  cmd_ready, bus_a, bus_b, alu_sel,
    input  res_valid, res_data, res_rd, res_flag_n, res_flag_z
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ra, cmd_rd, cmd_imm,
    input  alu_out, flag_n, flag_c,
    input  res_ready,
    output cmd_ready, bus_a, bus_b, alu_sel,
    output res_valid, res_data, res_rd, res_flag_n, res_flag_z
  );

endinterface

// File: rtl/alu_issue_wb.sv
// Two-entry issue/writeback pipeline around an external combinational ALU,
// with a small register file written from the writeback stage.
module alu_issue_wb
  import alu_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  alu_issue_wb_if.slave io
);

  cmd_t              e_cmd_q, e_cmd_d;
  logic              e_valid_q, e_valid_d;

  logic              res_valid_q, res_valid_d;
  logic [WIDTH-1:0]  res_data_q, res_data_d;
  logic [REG_AW-1:0] res_rd_q, res_rd_d;
  logic              res_flag_n_q, res_flag_n_d;
  logic              res_flag_z_q, res_flag_z_d;

  logic [WIDTH-1:0]  rf_q [NREGS];

  logic w_ready;
  logic cmd_fire;
  logic w_fire;

  assign w_ready      = !res_valid_q || io.res_ready;
  assign io.cmd_ready = !e_valid_q || w_ready;
  assign cmd_fire     = io.cmd_valid && io.cmd_ready;
  assign w_fire       = e_valid_q && w_ready;

  // LDI routes the immediate through the ALU as a pass so the result path stays uniform.
  always_comb begin
    // NOTE: defaults first on every path, so no signal here can infer a latch.
    io.bus_a   = rf_q[e_cmd_q.ra];
    io.bus_b   = e_cmd_q.imm;
    io.alu_sel = e_cmd_q.op;
    if (e_cmd_q.op == OP_LDI) begin
      io.bus_a   = e_cmd_q.imm;
      io.bus_b   = '0;
      io.alu_sel = OP_PASS;
    end
  end

  always_comb begin
    e_cmd_d      = e_cmd_q;
    e_valid_d    = e_valid_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_rd_d     = res_rd_q;
    res_flag_n_d = res_flag_n_q;
    res_flag_z_d = res_flag_z_q;

    if (cmd_fire) begin
      e_cmd_d   = '{op: io.cmd_op, ra: io.cmd_ra, rd: io.cmd_rd, imm: io.cmd_imm};
      e_valid_d = 1'b1;
    end else if (w_fire) begin
      e_valid_d = 1'b0;
    end

    if (w_fire) begin
      res_valid_d  = 1'b1;
      res_data_d   = io.alu_out;
      res_rd_d     = e_cmd_q.rd;
      res_flag_n_d = io.flag_n;
      res_flag_z_d = io.flag_c;
    end else if (io.res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      e_cmd_q      <= '0;
      e_valid_q    <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_rd_q     <= '0;
      res_flag_n_q <= 1'b0;
      res_flag_z_q <= 1'b0;
    end else begin
      e_cmd_q      <= e_cmd_d;
      e_valid_q    <= e_valid_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_rd_q     <= res_rd_d;
      res_flag_n_q <= res_flag_n_d;
      res_flag_z_q <= res_flag_z_d;
    end
  end

  // The write lands on the same edge that loads the next command into E,
  // so a dependent command reads the new value without forwarding.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this array is reset because it is only NREGS flops and must read as zero after reset.
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (w_fire) begin
      rf_q[e_cmd_q.rd] <= io.alu_out;
    end
  end

  assign io.res_valid  = res_valid_q;
  assign io.res_data   = res_data_q;
  assign io.res_rd     = res_rd_q;
  assign io.res_flag_n = res_flag_n_q;
  assign io.res_flag_z = res_flag_z_q;

endmodule

// File: tb/tb_alu_issue_wb.sv
// Bench for alu_issue_wb: a stand-in ALU on the operand bus, and a command-level
// reference model (register array + expected-result queue) checking every result.
module tb_alu_issue_wb;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_wb_if bus ();

  alu_issue_wb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  // Stand-in for the neighbouring ALU, written with bit-level signed operations.
  always_comb begin
    logic signed [WIDTH-1:0] a, b, r;
    a = bus.bus_a;
    b = bus.bus_b;
    case (bus.alu_sel)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_MUL:  r = a * b;
      OP_DIV2: r = $signed(a + {{(WIDTH-1){1'b0}}, a[WIDTH-1]}) >>> 1;
      default: r = a;
    endcase
    bus.alu_out = r;
    bus.flag_n  = r[WIDTH-1];
    bus.flag_c  = (r == '0);
  end

  typedef struct {
    logic [WIDTH-1:0]  data;
    logic [REG_AW-1:0] rd;
    logic              n;
    logic              z;
    int                cyc;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] rf_m [NREGS];
  int               total = 0;
  int               bad = 0;
  int               cyc = 0;
  int               delivered = 0;
  bit               lat_chk = 1'b0;
  logic [WIDTH-1:0] last_data;
  logic             last_n, last_z;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Sequential semantics: each command sees all earlier commands' results.
  task automatic model_issue(input logic [W_ALU_SEL-1:0] op, input logic [REG_AW-1:0] ra,
                             input logic [REG_AW-1:0] rd, input logic [WIDTH-1:0] imm);
    int   a, b, r;
    exp_t e;
    a = $signed(rf_m[ra]);
    b = $signed(imm);
    case (op)
      3'd7:    r = b;
      3'd1:    r = a + b;
      3'd2:    r = a - b;
      3'd3:    r = a * b;
      3'd4:    r = a / 2;
      default: r = a;
    endcase
    e.data = r[WIDTH-1:0];
    e.rd   = rd;
    e.n    = r[WIDTH-1];
    e.z    = (r[WIDTH-1:0] == '0);
    e.cyc  = cyc;
    rf_m[rd] = e.data;
    exp_q.push_back(e);
  endtask

  // One clock: drive at the falling edge, sample 1 time unit later, account handshakes.
  task automatic cycle(input logic cv, input logic [W_ALU_SEL-1:0] op, input logic [REG_AW-1:0] ra,
                       input logic [REG_AW-1:0] rd, input logic [WIDTH-1:0] imm, input logic rr,
                       output logic acc);
    exp_t e;
    @(negedge clk);
    bus.cmd_valid = cv;
    bus.cmd_op    = op;
    bus.cmd_ra    = ra;
    bus.cmd_rd    = rd;
    bus.cmd_imm   = imm;
    bus.res_ready = rr;
    #1;
    cyc++;
    if (bus.res_valid && rr) begin
      if (exp_q.size() == 0) begin
        check("spurious_res", 32'(bus.res_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("res_data", 32'(bus.res_data), 32'(e.data));
        check("res_rd", 32'(bus.res_rd), 32'(e.rd));
        check("res_flag_n", 32'(bus.res_flag_n), 32'(e.n));
        check("res_flag_z", 32'(bus.res_flag_z), 32'(e.z));
        if (lat_chk) check("latency", cyc - e.cyc, 32'd2);
        last_data = bus.res_data;
        last_n    = bus.res_flag_n;
        last_z    = bus.res_flag_z;
        delivered++;
      end
    end
    acc = cv && bus.cmd_ready;
    if (acc) model_issue(op, ra, rd, imm);
  endtask

  task automatic issue(input logic [W_ALU_SEL-1:0] op, input logic [REG_AW-1:0] ra,
                       input logic [REG_AW-1:0] rd, input logic [WIDTH-1:0] imm);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, op, ra, rd, imm, 1'b1, acc);
      if (acc) break;
    end
    if (!acc) check("issue_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++)
      cycle(1'b0, 3'd0, 2'd0, 2'd0, 8'd0, 1'b1, acc);
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    logic                 acc;
    int                   idx, d0;
    logic [31:0]          snap, now_v;
    logic [W_ALU_SEL-1:0] op5  [3];
    logic [REG_AW-1:0]    ra5  [3];
    logic [REG_AW-1:0]    rd5  [3];
    logic [WIDTH-1:0]     imm5 [3];

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_ra    = '0;
    bus.cmd_rd    = '0;
    bus.cmd_imm   = '0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < NREGS; i++) rf_m[i] = '0;

    // Reset state
    #1;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_bus_a", 32'(bus.bus_a), 32'd0);
    check("rst_bus_b", 32'(bus.bus_b), 32'd0);
    check("rst_alu_sel", 32'(bus.alu_sel), 32'd0);
    check("rst_res_data", 32'(bus.res_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: pass of a cleared register
    issue(OP_PASS, 2'd2, 2'd0, 8'd0);
    drain();
    check("t1_data", 32'(last_data), 32'd0);
    check("t1_z", 32'(last_z), 32'd1);

    // 2: back-to-back dependent commands, one result per cycle
    lat_chk = 1'b1;
    issue(OP_LDI, 2'd0, 2'd1, 8'd5);
    issue(OP_ADD, 2'd1, 2'd2, 8'hFD);
    drain();
    lat_chk = 1'b0;
    check("t2_data", 32'(last_data), 32'd2);
    issue(OP_PASS, 2'd2, 2'd3, 8'd0);
    drain();
    check("t2_rf2", 32'(last_data), 32'd2);

    // 3: zero result and truncated product
    issue(OP_SUB, 2'd1, 2'd3, 8'd5);
    drain();
    check("t3_sub", 32'(last_data), 32'd0);
    check("t3_sub_z", 32'(last_z), 32'd1);
    check("t3_sub_n", 32'(last_n), 32'd0);
    issue(OP_MUL, 2'd1, 2'd0, 8'hE2);
    drain();
    check("t3_mul", 32'(last_data), 32'h6A);
    check("t3_mul_n", 32'(last_n), 32'd0);

    // 4: halving a negative value rounds toward zero
    issue(OP_LDI, 2'd0, 2'd1, 8'hF9);
    issue(OP_DIV2, 2'd1, 2'd1, 8'd0);
    drain();
    check("t4_div2", 32'(last_data), 32'hFD);
    check("t4_div2_n", 32'(last_n), 32'd1);

    // 5: backpressure fills both entries, then releases in order
    op5[0] = OP_ADD; ra5[0] = 2'd1; rd5[0] = 2'd2; imm5[0] = 8'd10;
    op5[1] = OP_SUB; ra5[1] = 2'd2; rd5[1] = 2'd2; imm5[1] = 8'd3;
    op5[2] = OP_MUL; ra5[2] = 2'd2; rd5[2] = 2'd3; imm5[2] = 8'd3;
    idx  = 0;
    d0   = delivered;
    snap = '0;
    for (int i = 0; i < 5; i++) begin
      cycle(idx < 3, op5[idx < 3 ? idx : 2], ra5[idx < 3 ? idx : 2], rd5[idx < 3 ? idx : 2],
            imm5[idx < 3 ? idx : 2], 1'b0, acc);
      if (acc) idx++;
      now_v = {2'b00, bus.res_valid, bus.res_rd, bus.res_data, bus.bus_a, bus.alu_sel, bus.bus_b};
      if (i >= 2) check("t5_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      if (i == 2) snap = now_v;
      if (i > 2) check("t5_stable", now_v, snap);
    end
    check("t5_accepted", idx, 32'd2);
    for (int i = 0; i < 10 && idx < 3; i++) begin
      cycle(1'b1, op5[idx], ra5[idx], rd5[idx], imm5[idx], 1'b1, acc);
      if (acc) idx++;
    end
    drain();
    check("t5_delivered", delivered - d0, 32'd3);
    check("t5_last", 32'(last_data), 32'd12);

    // 6: reset with both stages full
    cycle(1'b1, OP_LDI, 2'd0, 2'd1, 8'd33, 1'b0, acc);
    cycle(1'b1, OP_LDI, 2'd0, 2'd2, 8'd44, 1'b0, acc);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_res_valid", 32'(bus.res_valid), 32'd0);
    check("t6_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("t6_bus_a", 32'(bus.bus_a), 32'd0);
    exp_q.delete();
    for (int i = 0; i < NREGS; i++) rf_m[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(OP_ADD, 2'd1, 2'd0, 8'd1);
    drain();
    check("t6_add", 32'(last_data), 32'd1);
    for (int r = 0; r < NREGS; r++) issue(OP_PASS, 2'(r), 2'(r), 8'd0);
    drain();

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 3'($urandom), 2'($urandom), 2'($urandom), 8'($urandom),
            $urandom_range(0, 3) != 0, acc);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
